memory_bus_xbar: RTL and testbench

- Parametrised successor to the single-CPU memory bus: N_MASTERS requestors (I-fetch, D-port, DMA, debug) share one on-chip SRAM port and one external DDR request port.
- Fair round-robin arbitration, one transaction in flight.
- Address decode with a decode-error response and a watchdog timeout, so a bad address or a dead slave never hangs a master.
- Sits between the core/DMA ports and the SRAM macro / DDR controller.

---
 rtl/memory_bus_xbar.sv | 266 ++++++++++++++++++++++++++
 tb/tb_memory_bus_xbar.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bus_xbar.sv
// memory_bus_xbar: round-robin crossbar from N_MASTERS requestors onto one SRAM port and one
// DDR request port. Only one transaction is in flight at a time. A bad address gets a
// decode-error response, and a silent slave gets a watchdog-timeout error response.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   m_req_*                  flattened per-master request (valid/ready/addr/we/wdata/be)
//   m_resp_valid/rdata/err   one-hot response pulse with shared data and error flag
//   sram_*                   SRAM request strobes/fields, sram_ready/sram_rdata return
//   mem_req_*/mem_resp_*     DDR controller request and response handshakes
//   perf_grant_cnt, perf_err_cnt  only with MEMBUS_PERF_CNT_EN: saturating grant/error counts
//
// Optional feature macro: MEMBUS_PERF_CNT_EN
module memory_bus_xbar #(
    parameter int unsigned           N_MASTERS      = 4,
    parameter int unsigned           ADDR_WIDTH     = 64,
    parameter int unsigned           DATA_WIDTH     = 64,
    parameter logic [ADDR_WIDTH-1:0] SRAM_BASE      = ADDR_WIDTH'(64'h0),
    parameter logic [ADDR_WIDTH-1:0] SRAM_SIZE      = ADDR_WIDTH'(64'h10_0000),
    parameter logic [ADDR_WIDTH-1:0] DDR_BASE       = ADDR_WIDTH'(64'h8000_0000),
    parameter int unsigned           TIMEOUT_CYCLES = 256
) (
    input  logic                              clk,
    input  logic                              rst_n,
`ifdef MEMBUS_PERF_CNT_EN
    output logic [N_MASTERS*32-1:0]           perf_grant_cnt,
    output logic [31:0]                       perf_err_cnt,
`endif
    input  logic [N_MASTERS-1:0]              m_req_valid,
    output logic [N_MASTERS-1:0]              m_req_ready,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]   m_req_addr,
    input  logic [N_MASTERS-1:0]              m_req_we,
    input  logic [N_MASTERS*DATA_WIDTH-1:0]   m_req_wdata,
    input  logic [N_MASTERS*DATA_WIDTH/8-1:0] m_req_be,
    output logic [N_MASTERS-1:0]              m_resp_valid,
    output logic [DATA_WIDTH-1:0]             m_resp_rdata,
    output logic                              m_resp_err,
    output logic [ADDR_WIDTH-1:0]             sram_addr,
    output logic [DATA_WIDTH-1:0]             sram_wdata,
    output logic [DATA_WIDTH/8-1:0]           sram_be,
    output logic                              sram_we,
    output logic                              sram_re,
    input  logic [DATA_WIDTH-1:0]             sram_rdata,
    input  logic                              sram_ready,
    output logic                              mem_req_valid,
    input  logic                              mem_req_ready,
    output logic [ADDR_WIDTH-1:0]             mem_req_addr,
    output logic                              mem_req_we,
    output logic [DATA_WIDTH-1:0]             mem_req_wdata,
    output logic [DATA_WIDTH/8-1:0]           mem_req_be,
    output logic [2:0]                        mem_req_burst_len,
    input  logic                              mem_resp_valid,
    output logic                              mem_resp_ready,
    input  logic [DATA_WIDTH-1:0]             mem_resp_rdata
);

    localparam int unsigned BE_W  = DATA_WIDTH / 8;
    localparam int unsigned IDX_W = $clog2(N_MASTERS);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {StIdle, StSram, StDdrReq, StDdrResp, StErr, StResp} state_e;

    state_e                  r_state, w_state_d;
    logic                    r_alive;  // low for the first cycle after reset so outputs stay 0
    logic [IDX_W-1:0]        r_ptr, w_ptr_d, r_id, w_id_d;
    logic [ADDR_WIDTH-1:0]   r_addr, w_addr_d;
    logic                    r_we, w_we_d;
    logic [DATA_WIDTH-1:0]   r_wdata, w_wdata_d, r_rdata, w_rdata_d;
    logic [BE_W-1:0]         r_be, w_be_d;
    logic                    r_err, w_err_d;
    logic [CNT_W-1:0]        r_cnt, w_cnt_d;

    logic [ADDR_WIDTH-1:0]   w_addr_arr  [N_MASTERS];
    logic [DATA_WIDTH-1:0]   w_wdata_arr [N_MASTERS];
    logic [BE_W-1:0]         w_be_arr    [N_MASTERS];
    logic                    w_gnt_vld, w_grant, w_hit_sram, w_hit_ddr, w_timeout;
    logic [IDX_W-1:0]        w_gnt_idx, w_cand;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_unpack
        assign w_addr_arr[i]  = m_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_wdata_arr[i] = m_req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        assign w_be_arr[i]    = m_req_be[i*BE_W +: BE_W];
    end

    // Round-robin search starting just after the last winner, plus region decode of the winner.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int k = 1; k <= int'(N_MASTERS); k++) begin
            w_cand = IDX_W'((int'(r_ptr) + k) % int'(N_MASTERS));
            if (!w_gnt_vld && m_req_valid[w_cand]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
        w_sel_addr = w_addr_arr[w_gnt_idx];
        // Subtract-then-compare so a region touching the top of the space cannot overflow.
        w_hit_sram = (w_sel_addr >= SRAM_BASE) && ((w_sel_addr - SRAM_BASE) < SRAM_SIZE);
        w_hit_ddr  = (w_sel_addr >= DDR_BASE);
    end

    assign w_grant   = (r_state == StIdle) && r_alive && w_gnt_vld;
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    assign sram_addr         = r_addr;
    assign sram_wdata        = r_wdata;
    assign sram_be           = r_be;
    assign mem_req_addr      = r_addr;
    assign mem_req_we        = r_we;
    assign mem_req_wdata     = r_wdata;
    assign mem_req_be        = r_be;
    assign mem_req_burst_len = 3'd0;
    assign m_resp_rdata      = r_rdata;
    assign m_resp_err        = r_err;

    always_comb begin
        w_state_d      = r_state;
        w_ptr_d        = r_ptr;
        w_id_d         = r_id;
        w_addr_d       = r_addr;
        w_we_d         = r_we;
        w_wdata_d      = r_wdata;
        w_be_d         = r_be;
        w_rdata_d      = r_rdata;
        w_err_d        = r_err;
        w_cnt_d        = r_cnt;
        m_req_ready    = '0;
        m_resp_valid   = '0;
        sram_re        = 1'b0;
        sram_we        = 1'b0;
        mem_req_valid  = 1'b0;
        mem_resp_ready = 1'b0;
        unique case (r_state)
            StIdle: begin
                // Swallows a response that arrives after its transaction timed out.
                mem_resp_ready = r_alive;
                if (w_grant) begin
                    m_req_ready[w_gnt_idx] = 1'b1;
                    w_ptr_d   = w_gnt_idx;
                    w_id_d    = w_gnt_idx;
                    w_addr_d  = w_sel_addr;
                    w_we_d    = m_req_we[w_gnt_idx];
                    w_wdata_d = w_wdata_arr[w_gnt_idx];
                    w_be_d    = w_be_arr[w_gnt_idx];
                    w_rdata_d = '0;
                    w_err_d   = 1'b0;
                    w_cnt_d   = '0;
                    if (w_hit_sram)     w_state_d = StSram;
                    else if (w_hit_ddr) w_state_d = StDdrReq;
                    else                w_state_d = StErr;
                end
            end
            StSram: begin
                w_cnt_d = r_cnt + CNT_W'(1);
                if (w_timeout) begin
                    w_err_d   = 1'b1;
                    w_rdata_d = '0;
                    w_state_d = StResp;
                end else begin
                    sram_re = !r_we;
                    sram_we = r_we;
                    if (sram_ready) begin
                        w_rdata_d = r_we ? '0 : sram_rdata;
                        w_state_d = StResp;
                    end
                end
            end
            StDdrReq: begin
                w_cnt_d = r_cnt + CNT_W'(1);
                if (w_timeout) begin
                    w_err_d   = 1'b1;
                    w_rdata_d = '0;
                    w_state_d = StResp;
                end else begin
                    mem_req_valid = 1'b1;
                    if (mem_req_ready) begin
                        w_cnt_d   = '0;
                        w_state_d = r_we ? StResp : StDdrResp;
                    end
                end
            end
            StDdrResp: begin
                mem_resp_ready = 1'b1;
                w_cnt_d        = r_cnt + CNT_W'(1);
                // A response landing on the final wait cycle still wins over the timeout.
                if (mem_resp_valid) begin
                    w_rdata_d = mem_resp_rdata;
                    w_state_d = StResp;
                end else if (w_timeout) begin
                    w_err_d   = 1'b1;
                    w_rdata_d = '0;
                    w_state_d = StResp;
                end
            end
            StErr: begin
                w_err_d   = 1'b1;
                w_rdata_d = '0;
                w_state_d = StResp;
            end
            StResp: begin
                m_resp_valid[r_id] = 1'b1;
                w_state_d          = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_alive <= 1'b0;
            r_ptr   <= IDX_W'(N_MASTERS - 1);
            r_id    <= '0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_wdata <= '0;
            r_be    <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_alive <= 1'b1;
            r_ptr   <= w_ptr_d;
            r_id    <= w_id_d;
            r_addr  <= w_addr_d;
            r_we    <= w_we_d;
            r_wdata <= w_wdata_d;
            r_be    <= w_be_d;
            r_rdata <= w_rdata_d;
            r_err   <= w_err_d;
            r_cnt   <= w_cnt_d;
        end
    end

`ifdef MEMBUS_PERF_CNT_EN
    logic [31:0] r_perf_grant [N_MASTERS];
    logic [31:0] r_perf_err;
    logic        w_err_evt;

    // Decode errors and timeouts both enter RESP with the error flag set.
    assign w_err_evt = (w_state_d == StResp) && (r_state != StResp) && w_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_MASTERS); i++) r_perf_grant[i] <= '0;
            r_perf_err <= '0;
        end else begin
            if (w_grant && (r_perf_grant[w_gnt_idx] != '1)) begin
                r_perf_grant[w_gnt_idx] <= r_perf_grant[w_gnt_idx] + 32'd1;
            end
            if (w_err_evt && (r_perf_err != '1)) r_perf_err <= r_perf_err + 32'd1;
        end
    end

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_perf
        assign perf_grant_cnt[i*32 +: 32] = r_perf_grant[i];
    end
    assign perf_err_cnt = r_perf_err;
`else
    // Performance counters compiled out; the datapath above is unaffected.
`endif

endmodule

// File: tb/tb_memory_bus_xbar.sv
module tb_memory_bus_xbar;
    localparam int N  = 4;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int BW = DW / 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      m_req_valid = '0;
    logic [N-1:0]      m_req_ready;
    logic [N*AW-1:0]   m_req_addr = '0;
    logic [N-1:0]      m_req_we = '0;
    logic [N*DW-1:0]   m_req_wdata = '0;
    logic [N*BW-1:0]   m_req_be = '1;
    logic [N-1:0]      m_resp_valid;
    logic [DW-1:0]     m_resp_rdata;
    logic              m_resp_err;
    logic [AW-1:0]     sram_addr;
    logic [DW-1:0]     sram_wdata;
    logic [BW-1:0]     sram_be;
    logic              sram_we, sram_re;
    logic [DW-1:0]     sram_rdata = '0;
    logic              sram_ready = 1'b0;
    logic              mem_req_valid;
    logic              mem_req_ready = 1'b0;
    logic [AW-1:0]     mem_req_addr;
    logic              mem_req_we;
    logic [DW-1:0]     mem_req_wdata;
    logic [BW-1:0]     mem_req_be;
    logic [2:0]        mem_req_burst_len;
    logic              mem_resp_valid = 1'b0;
    logic              mem_resp_ready;
    logic [DW-1:0]     mem_resp_rdata = '0;
`ifdef MEMBUS_PERF_CNT_EN
    logic [N*32-1:0]   perf_grant_cnt;
    logic [31:0]       perf_err_cnt;
`endif

    int checks = 0;
    int errors = 0;

    memory_bus_xbar #(
        .N_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef MEMBUS_PERF_CNT_EN
        .perf_grant_cnt(perf_grant_cnt), .perf_err_cnt(perf_err_cnt),
`endif
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
        .m_req_we(m_req_we), .m_req_wdata(m_req_wdata), .m_req_be(m_req_be),
        .m_resp_valid(m_resp_valid), .m_resp_rdata(m_resp_rdata), .m_resp_err(m_resp_err),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_be(sram_be),
        .sram_we(sram_we), .sram_re(sram_re), .sram_rdata(sram_rdata),
        .sram_ready(sram_ready), .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_we(mem_req_we), .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
        .mem_req_burst_len(mem_req_burst_len), .mem_resp_valid(mem_resp_valid),
        .mem_resp_ready(mem_resp_ready), .mem_resp_rdata(mem_resp_rdata)
    );

    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic set_req(input int idx, input logic [AW-1:0] addr, input logic we,
                           input logic [DW-1:0] wdata);
        m_req_addr[idx*AW +: AW]  = addr;
        m_req_we[idx]             = we;
        m_req_wdata[idx*DW +: DW] = wdata;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        m_req_valid = 4'hF;
        @(negedge clk); #1;
        checks++;
        if (m_req_ready !== 4'h0) begin
            errors++; $display("FAIL reset_ready: got %b expected 0000", m_req_ready);
        end
        checks++;
        if (m_resp_valid !== 4'h0) begin
            errors++; $display("FAIL reset_resp_valid: got %b expected 0000", m_resp_valid);
        end
        checks++;
        if ({sram_re, sram_we, mem_req_valid, mem_resp_ready} !== 4'b0) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 0000",
                     {sram_re, sram_we, mem_req_valid, mem_resp_ready});
        end
        checks++;
        if ({m_resp_err, m_resp_rdata} !== 65'h0) begin
            errors++;
            $display("FAIL reset_resp_data: got err %b rdata %h expected 0/0", m_resp_err,
                     m_resp_rdata);
        end
        m_req_valid = '0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        logic [N-1:0] exp_oh;
        sram_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 64'h10 * i, 1'b0, '0);
        for (int t = 0; t < 5; t++) begin
            exp_oh = 4'b0001 << (t % N);
            @(negedge clk);
            m_req_valid = 4'hF;
            sram_rdata  = 64'h1000 + 64'(t);
            #1;
            checks++;
            if (m_req_ready !== exp_oh) begin
                errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", t, m_req_ready, exp_oh);
            end
            @(negedge clk); #1;
            checks++;
            if ({m_req_ready, sram_re, sram_addr} !== {4'h0, 1'b1, 64'h10 * 64'(t % N)}) begin
                errors++;
                $display("FAIL rr_sram[%0d]: got ready %b re %b addr %h", t, m_req_ready, sram_re,
                         sram_addr);
            end
            @(negedge clk); #1;
            checks++;
            if ({m_resp_valid, m_resp_err, m_resp_rdata} !== {exp_oh, 1'b0, 64'h1000 + 64'(t)}) begin
                errors++;
                $display("FAIL rr_resp[%0d]: got valid %b err %b rdata %h expected %b 0 %h", t,
                         m_resp_valid, m_resp_err, m_resp_rdata, exp_oh, 64'h1000 + 64'(t));
            end
        end
        @(negedge clk);
        m_req_valid = '0;
    endtask

    task automatic test_sram_read;
        @(negedge clk);
        set_req(1, 64'h100, 1'b0, '0);
        sram_ready  = 1'b1;
        sram_rdata  = 64'hDEAD_BEEF;
        m_req_valid = 4'b0010;
        #1;
        checks++;
        if (m_req_ready !== 4'b0010) begin
            errors++; $display("FAIL sram_rd_grant: got %b expected 0010", m_req_ready);
        end
        @(negedge clk);
        m_req_valid = '0;
        #1;
        checks++;
        if ({sram_re, sram_we, sram_addr, m_resp_valid} !== {1'b1, 1'b0, 64'h100, 4'h0}) begin
            errors++;
            $display("FAIL sram_rd_strobe: got re %b we %b addr %h resp %b", sram_re, sram_we,
                     sram_addr, m_resp_valid);
        end
        @(negedge clk); #1;
        checks++;
        if ({m_resp_valid, m_resp_err, m_resp_rdata} !== {4'b0010, 1'b0, 64'hDEAD_BEEF}) begin
            errors++;
            $display("FAIL sram_rd_resp: got valid %b err %b rdata %h expected 0010 0 deadbeef",
                     m_resp_valid, m_resp_err, m_resp_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_ddr_write;
        @(negedge clk);
        set_req(2, 64'h8000_0040, 1'b1, 64'h1234);
        sram_ready    = 1'b0;
        mem_req_ready = 1'b0;
        m_req_valid   = 4'b0100;
        #1;
        checks++;
        if (m_req_ready !== 4'b0100) begin
            errors++; $display("FAIL ddr_wr_grant: got %b expected 0100", m_req_ready);
        end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            m_req_valid   = '0;
            mem_req_ready = (c == 4);
            #1;
            checks++;
            if ({mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_be,
                 mem_req_burst_len} !== {1'b1, 64'h8000_0040, 1'b1, 64'h1234, 8'hFF, 3'd0}) begin
                errors++;
                $display("FAIL ddr_wr_hold[%0d]: got v %b a %h we %b d %h be %h bl %0d", c,
                         mem_req_valid, mem_req_addr, mem_req_we, mem_req_wdata, mem_req_be,
                         mem_req_burst_len);
            end
        end
        @(negedge clk);
        mem_req_ready = 1'b0;
        #1;
        checks++;
        if ({m_resp_valid, m_resp_err, mem_req_valid} !== {4'b0100, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL ddr_wr_resp: got valid %b err %b mem_req_valid %b", m_resp_valid,
                     m_resp_err, mem_req_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_decode_err;
        @(negedge clk);
        set_req(0, 64'h4000_0000, 1'b0, '0);
        sram_ready  = 1'b1;
        m_req_valid = 4'b0001;
        #1;
        checks++;
        if (m_req_ready !== 4'b0001) begin
            errors++; $display("FAIL dec_err_grant: got %b expected 0001", m_req_ready);
        end
        @(negedge clk);
        m_req_valid = '0;
        #1;
        checks++;
        if ({sram_re, sram_we, mem_req_valid, m_resp_valid} !== 7'b0) begin
            errors++;
            $display("FAIL dec_err_strobes: got re %b we %b mv %b resp %b", sram_re, sram_we,
                     mem_req_valid, m_resp_valid);
        end
        @(negedge clk); #1;
        checks++;
        if ({m_resp_valid, m_resp_err, m_resp_rdata} !== {4'b0001, 1'b1, 64'h0}) begin
            errors++;
            $display("FAIL dec_err_resp: got valid %b err %b rdata %h expected 0001 1 0",
                     m_resp_valid, m_resp_err, m_resp_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        @(negedge clk);
        set_req(3, 64'h9000_0000, 1'b0, '0);
        sram_ready    = 1'b0;
        mem_req_ready = 1'b1;
        m_req_valid   = 4'b1000;
        #1;
        checks++;
        if (m_req_ready !== 4'b1000) begin
            errors++; $display("FAIL to_grant: got %b expected 1000", m_req_ready);
        end
        @(negedge clk);
        m_req_valid = '0;
        #1;
        checks++;
        if ({mem_req_valid, mem_req_we, mem_req_addr} !== {1'b1, 1'b0, 64'h9000_0000}) begin
            errors++;
            $display("FAIL to_req: got v %b we %b addr %h", mem_req_valid, mem_req_we,
                     mem_req_addr);
        end
        for (int c = 0; c < 16; c++) begin
            @(negedge clk); #1;
            checks++;
            if ({mem_resp_ready, m_resp_valid} !== {1'b1, 4'h0}) begin
                errors++;
                $display("FAIL to_wait[%0d]: got resp_ready %b resp_valid %b", c, mem_resp_ready,
                         m_resp_valid);
            end
        end
        @(negedge clk); #1;
        checks++;
        if ({m_resp_valid, m_resp_err, m_resp_rdata, mem_resp_ready} !==
            {4'b1000, 1'b1, 64'h0, 1'b0}) begin
            errors++;
            $display("FAIL to_resp: got valid %b err %b rdata %h rr %b", m_resp_valid, m_resp_err,
                     m_resp_rdata, mem_resp_ready);
        end
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'hBAD;
        #1;
        checks++;
        if ({mem_resp_ready, m_resp_valid} !== {1'b1, 4'h0}) begin
            errors++;
            $display("FAIL to_late: got resp_ready %b resp_valid %b", mem_resp_ready,
                     m_resp_valid);
        end
        @(negedge clk);
        mem_resp_valid = 1'b0;
        set_req(1, 64'h8000_0100, 1'b0, '0);
        m_req_valid = 4'b0010;
        #1;
        checks++;
        if (m_req_ready !== 4'b0010) begin
            errors++; $display("FAIL to_next_grant: got %b expected 0010", m_req_ready);
        end
        @(negedge clk);
        m_req_valid = '0;
        #1;
        checks++;
        if ({mem_req_valid, mem_req_addr} !== {1'b1, 64'h8000_0100}) begin
            errors++;
            $display("FAIL to_next_req: got v %b addr %h", mem_req_valid, mem_req_addr);
        end
        @(negedge clk);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = 64'hCAFE;
        #1;
        checks++;
        if ({mem_resp_ready, m_resp_valid} !== {1'b1, 4'h0}) begin
            errors++;
            $display("FAIL to_next_wait: got rr %b resp %b", mem_resp_ready, m_resp_valid);
        end
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b0;
        #1;
        checks++;
        if ({m_resp_valid, m_resp_err, m_resp_rdata} !== {4'b0010, 1'b0, 64'hCAFE}) begin
            errors++;
            $display("FAIL to_next_resp: got valid %b err %b rdata %h expected 0010 0 cafe",
                     m_resp_valid, m_resp_err, m_resp_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        set_req(2, 64'h8000_0080, 1'b1, 64'h55);
        mem_req_ready = 1'b0;
        m_req_valid   = 4'b0100;
        #1;
        checks++;
        if (m_req_ready !== 4'b0100) begin
            errors++; $display("FAIL rst_mid_grant: got %b expected 0100", m_req_ready);
        end
        @(negedge clk);
        m_req_valid = '0;
        #1;
        checks++;
        if (mem_req_valid !== 1'b1) begin
            errors++; $display("FAIL rst_mid_req: got %b expected 1", mem_req_valid);
        end
        #2;
        rst_n = 1'b0;
        set_req(0, 64'h300, 1'b0, '0);
        sram_ready  = 1'b1;
        sram_rdata  = 64'h77;
        m_req_valid = 4'hF;
        #1;
        checks++;
        if ({m_req_ready, m_resp_valid, sram_re, sram_we, mem_req_valid, mem_resp_ready,
             mem_req_addr, m_resp_err, m_resp_rdata} !== '0) begin
            errors++;
            $display("FAIL rst_mid_zero: rdy %b rv %b re %b we %b mv %b rr %b ma %h err %b rd %h",
                     m_req_ready, m_resp_valid, sram_re, sram_we, mem_req_valid, mem_resp_ready,
                     mem_req_addr, m_resp_err, m_resp_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({m_req_ready, m_resp_valid} !== {4'b0001, 4'h0}) begin
            errors++;
            $display("FAIL rst_mid_first: got ready %b resp %b expected 0001 0000", m_req_ready,
                     m_resp_valid);
        end
        @(negedge clk);
        m_req_valid = '0;
        @(negedge clk); #1;
        checks++;
        if ({m_resp_valid, m_resp_err, m_resp_rdata} !== {4'b0001, 1'b0, 64'h77}) begin
            errors++;
            $display("FAIL rst_mid_resp: got valid %b err %b rdata %h expected 0001 0 77",
                     m_resp_valid, m_resp_err, m_resp_rdata);
        end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_sram_read();
        test_ddr_write();
        test_decode_err();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
